// File: rtl/contador_nivel2_timer_pkg.sv
// rtl/contador_nivel2_timer_pkg.sv - shared BCD digit constants and clamp helper
package contador_nivel2_timer_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_ZERO  = 4'd0;

  // Saturate a keypad/shifted digit so stored digits are always legal BCD for their position.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] value,
                                                    input logic [BCD_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/contador_nivel2_timer_bcd_down_digit.sv
// rtl/contador_nivel2_timer_bcd_down_digit.sv - one BCD down-counting digit with shift load
module bcd_down_digit
  import contador_nivel2_timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX_9
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             shift,
  input  logic [BCD_W-1:0] shift_in,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out,
  output logic             is_zero
);

  assign is_zero    = (q == DIGIT_ZERO);
  assign borrow_out = dec && is_zero;

  // Shift wins over decrement; underflow reloads the digit's maximum.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      q <= DIGIT_ZERO;
    end else if (shift) begin
      q <= clamp_digit(shift_in, MAX);
    end else if (dec) begin
      q <= is_zero ? MAX : (q - 4'd1);
    end
  end

endmodule

// File: rtl/contador_nivel2_timer.sv
// rtl/contador_nivel2_timer.sv - M:SS BCD countdown timer with serial keypad load
module contador_nivel2_timer
  import contador_nivel2_timer_pkg::*;
(
  input  logic       [3:0] data,
  input  logic             clock,
  input  logic             enable,
  input  logic             loadn,
  input  logic             clrn,
  output logic       [3:0] sec_ones,
  output logic       [3:0] sec_tens,
  output logic       [3:0] mins,
  output logic             timer_done
);

  logic shift;
  logic dec_ones;
  logic borrow_ones;
  logic borrow_tens;
  logic borrow_mins;
  logic zero_ones;
  logic zero_tens;
  logic zero_mins;

  assign shift      = !loadn;
  assign timer_done = zero_ones && zero_tens && zero_mins;
  // Blocking the decrement at 0:00 keeps the timer parked instead of wrapping to 9:59.
  assign dec_ones   = enable && loadn && !timer_done;

  bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_ones (
    .clock      (clock),
    .clrn       (clrn),
    .shift      (shift),
    .shift_in   (data),
    .dec        (dec_ones),
    .q          (sec_ones),
    .borrow_out (borrow_ones),
    .is_zero    (zero_ones)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX_5)) u_tens (
    .clock      (clock),
    .clrn       (clrn),
    .shift      (shift),
    .shift_in   (sec_ones),
    .dec        (borrow_ones),
    .q          (sec_tens),
    .borrow_out (borrow_tens),
    .is_zero    (zero_tens)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_mins (
    .clock      (clock),
    .clrn       (clrn),
    .shift      (shift),
    .shift_in   (sec_tens),
    .dec        (borrow_tens),
    .q          (mins),
    .borrow_out (borrow_mins),
    .is_zero    (zero_mins)
  );

  logic unused_borrow;
  assign unused_borrow = borrow_mins;

endmodule

// File: tb/tb_contador_nivel2_timer.sv
// tb/tb_contador_nivel2_timer.sv - directed self-checking bench for the countdown timer
module tb_contador_nivel2_timer;

  logic [3:0] data;
  logic       clock;
  logic       enable;
  logic       loadn;
  logic       clrn;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       timer_done;

  int total;
  int bad;

  contador_nivel2_timer dut (
    .data       (data),
    .clock      (clock),
    .enable     (enable),
    .loadn      (loadn),
    .clrn       (clrn),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .mins       (mins),
    .timer_done (timer_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed as {done, mins, tens, ones}.
  function automatic logic [12:0] exp_time(input int m, input int t, input int o);
    logic [3:0] mm;
    logic [3:0] tt;
    logic [3:0] oo;
    mm = 4'(m);
    tt = 4'(t);
    oo = 4'(o);
    return {(m == 0 && t == 0 && o == 0), mm, tt, oo};
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shift_digit(input logic [3:0] d);
    loadn = 1'b0;
    data  = d;
    tick();
    loadn = 1'b1;
  endtask

  function automatic logic [12:0] obs();
    return {timer_done, mins, sec_tens, sec_ones};
  endfunction

  initial begin
    total  = 0;
    bad    = 0;
    data   = 4'd0;
    enable = 1'b0;
    loadn  = 1'b1;
    clrn   = 1'b1;

    // Async clear with no clock edge in between.
    #2 clrn = 1'b0;
    #1 chk("reset_async", obs(), exp_time(0, 0, 0));
    #10;
    @(negedge clock);
    clrn = 1'b1;
    tick();
    chk("reset_hold", obs(), exp_time(0, 0, 0));

    shift_digit(4'd2);
    chk("load_2", obs(), exp_time(0, 0, 2));
    shift_digit(4'd1);
    chk("load_1", obs(), exp_time(0, 2, 1));
    shift_digit(4'd7);
    chk("load_7", obs(), exp_time(2, 1, 7));
    shift_digit(4'd9);
    chk("load_9_clamp", obs(), exp_time(1, 5, 9));

    enable = 1'b1;
    for (int i = 1; i <= 169; i++) begin
      tick();
      if (i == 1)   chk("cnt_1",   obs(), exp_time(1, 5, 8));
      if (i == 59)  chk("cnt_59",  obs(), exp_time(1, 0, 0));
      if (i == 60)  chk("cnt_60",  obs(), exp_time(0, 5, 9));
      if (i == 109) chk("cnt_109", obs(), exp_time(0, 1, 0));
      if (i == 110) chk("cnt_110", obs(), exp_time(0, 0, 9));
      if (i == 118) chk("cnt_118", obs(), exp_time(0, 0, 1));
      if (i == 119) chk("cnt_119", obs(), exp_time(0, 0, 0));
      if (i == 169) chk("cnt_hold_zero", obs(), exp_time(0, 0, 0));
    end

    enable = 1'b0;
    shift_digit(4'd0);
    shift_digit(4'd3);
    shift_digit(4'd0);
    chk("load_030", obs(), exp_time(0, 3, 0));
    repeat (10) tick();
    chk("hold_en0", obs(), exp_time(0, 3, 0));
    enable = 1'b1;
    tick();
    chk("reenable", obs(), exp_time(0, 2, 9));

    // Shift must win over count while enable stays high.
    loadn = 1'b0;
    data  = 4'd4;
    tick();
    loadn = 1'b1;
    chk("load_priority", obs(), exp_time(2, 5, 4));
    tick();
    chk("cnt_after_load", obs(), exp_time(2, 5, 3));

    enable = 1'b0;
    shift_digit(4'hF);
    chk("data_clamp", obs(), exp_time(5, 3, 9));
    shift_digit(4'd1);
    shift_digit(4'd2);
    shift_digit(4'd3);
    chk("load_123", obs(), exp_time(1, 2, 3));

    enable = 1'b1;
    tick();
    chk("cnt_122", obs(), exp_time(1, 2, 2));
    #2 clrn = 1'b0;
    #1 chk("clear_midcount", obs(), exp_time(0, 0, 0));
    @(negedge clock);
    clrn = 1'b1;
    tick();
    chk("after_clear", obs(), exp_time(0, 0, 0));
    tick();
    chk("after_clear2", obs(), exp_time(0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
